serial_sub_ctrl: RTL
====================

Name: serial_sub_ctrl

Overview:
Bit-serial subtractor controller. Accepts two WIDTH-bit operands and a borrow-in over a valid/ready handshake, then feeds one bit pair per cycle, LSB first, through a single 1-bit full subtractor. It registers the borrow between bits, assembles the difference in a shift register, and presents result plus final borrow until the consumer takes it. It trades WIDTH cycles of latency for one fullsub cell, for area-constrained arithmetic paths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  synchronous, active-high reset.
i_valid  input  1  operands present on i_a/i_b/i_bin.
o_ready  output  1  controller can accept operands (high only in IDLE).
i_a  input  WIDTH  minuend.
i_b  input  WIDTH  subtrahend.
i_bin  input  1  borrow-in for bit 0.
o_valid  output  1  result available.
i_ready  input  1  consumer takes result.
o_diff  output  WIDTH  difference (a - b - bin) mod 2^WIDTH.
o_borrow  output  1  final borrow-out; 1 when a < b + bin.
o_busy  output  1  high in RUN.

Behaviour:
- States: IDLE, RUN, DONE (encoding in package).
- Reset (i_rst high at a rising edge): state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_diff=0, o_borrow=0, counter=0, operand/borrow registers=0. Reset overrides all other inputs in that cycle.
- IDLE:
  - o_ready=1.
  - On an edge with i_valid=1, load shift registers with i_a and i_b, set the borrow register to i_bin, clear the counter, go to RUN.
  - With i_valid=0, stay in IDLE.
- RUN:
  - o_ready=0, o_busy=1.
  - Each edge, the cell computes d = a0^b0^br and bo = (~a0&br)|(b0&br)|(~a0&b0), using the current LSBs a0/b0 and borrow register br.
  - d shifts into the result MSB (result shifts right). The operand registers shift right. br<=bo. counter+1.
  - On the edge where counter==WIDTH-1, the last bit is processed and the state goes to DONE. RUN lasts exactly WIDTH edges.
- Latency: acceptance at edge k gives o_valid=1 in the cycle after edge k+WIDTH.
- DONE:
  - o_valid=1. o_diff and o_borrow are stable and must not change while i_ready=0.
  - i_valid is ignored and o_ready=0.
  - On an edge with i_ready=1, go to IDLE and set o_valid=0. o_diff/o_borrow keep their last values.
  - No same-cycle re-accept: the minimum issue interval is WIDTH+2 cycles.
- i_a/i_b/i_bin are sampled only at the acceptance edge. Later changes have no effect.
- i_ready outside DONE is ignored.
- Reset mid-RUN or in DONE aborts the operation and discards the partial result. Reset values apply on the next cycle.
- WIDTH=1: RUN lasts one edge and the counter compare is against 0.
- Arithmetic is unsigned modulo 2^WIDTH; o_borrow is the only overflow indication.

Decomposition:
- Package serial_sub_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and a function computing borrow-out from (a, b, bin) for use by the bench reference model.
- Sub-module: instantiate the existing 1-bit fullsub cell (i_a, i_b, i_c -> o_diff, o_borrow) for the per-bit computation. Do not duplicate its logic inline.
- FSM, counter and shift registers live in serial_sub_ctrl.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, i_ready=1 -> o_valid 8 edges after accept; o_diff=0x1E, o_borrow=0.
- WIDTH=8, a=0x00, b=0x01, bin=0 -> o_diff=0xFF, o_borrow=1; then a=0x10, b=0x10, bin=1 -> o_diff=0xFF, o_borrow=1.
- Back-pressure: a=0xC8, b=0x64, hold i_ready=0 for 5 cycles in DONE while toggling i_valid and operands -> o_diff=0x64, o_borrow=0 stable, o_ready=0; release i_ready -> IDLE next cycle, o_ready=1.
- Reset in RUN after 3 bit-edges -> next cycle IDLE, all outputs zero; a new request a=0x07, b=0x02 then gives o_diff=0x05, o_borrow=0.
- Operand change after accept: accept a=0xAA, b=0x55, then drive a=0xFF, b=0xFF during RUN -> o_diff=0x55, o_borrow=0.
- WIDTH=1 build: a=0, b=1, bin=0 -> o_valid after 1 edge; o_diff=1, o_borrow=1. Exhaustive 8 combos match the fullsub truth table.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor controller.
//   - FSM state encodings (IDLE / RUN / DONE) as 2-bit constants.
//   - borrow_out(): reference borrow-out of a multi-bit subtraction
//     a - b - bin, treating a and b as unsigned values of up to 32 bits.
// ---------------------------------------------------------------------------
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 1 when a < b + bin; computed one bit wider so b + bin cannot wrap.
    function automatic logic borrow_out(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        bin);
        logic [32:0] lhs;
        logic [32:0] rhs;
        lhs = {1'b0, a};
        rhs = {1'b0, b} + {32'd0, bin};
        return (lhs < rhs);
    endfunction

endpackage : serial_sub_pkg

// File: rtl/serial_sub_ctrl_fullsub.sv
// ---------------------------------------------------------------------------
// fullsub
// Combinational 1-bit full subtractor: computes i_a - i_b - i_c.
// Ports:
//   i_a      minuend bit
//   i_b      subtrahend bit
//   i_c      borrow-in
//   o_diff   difference bit
//   o_borrow borrow-out
// ---------------------------------------------------------------------------
module fullsub (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_diff,
    output logic o_borrow
);

    assign o_diff   = i_a ^ i_b ^ i_c;
    assign o_borrow = (~i_a & i_c) | (i_b & i_c) | (~i_a & i_b);

endmodule : fullsub

// File: rtl/serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl
// Bit-serial subtractor controller. Operands are accepted in IDLE, then one
// bit pair per cycle (LSB first) is pushed through a single fullsub cell.
// The borrow is carried between bits in a register and the difference is
// assembled MSB-first into a right-shifting result register. The result is
// held in DONE until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Input side: i_valid/o_ready (o_ready high only in IDLE).
// Output side: o_valid/i_ready (o_valid high only in DONE, and o_diff /
// o_borrow do not change while o_valid is high).
//
// Ports:
//   i_clk, i_rst       clock (rising edge), synchronous active-high reset
//   i_valid, o_ready   operand handshake
//   i_a, i_b, i_bin    minuend, subtrahend, borrow-in (sampled at accept)
//   o_valid, i_ready   result handshake
//   o_diff, o_borrow   (a - b - bin) mod 2^WIDTH and final borrow-out
//   o_busy             high while bits are being processed
// ---------------------------------------------------------------------------
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    // Counter value on the edge that processes the MSB.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             br_q,    br_d;
    logic [WIDTH-1:0] res_q,   res_d;

    logic cell_diff;
    logic cell_borrow;

    fullsub u_fullsub (
        .i_a      (a_q[0]),
        .i_b      (b_q[0]),
        .i_c      (br_q),
        .o_diff   (cell_diff),
        .o_borrow (cell_borrow)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    br_d    = i_bin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = cell_borrow;
                // New bit enters at the MSB; after WIDTH shifts bit 0 of the
                // difference has reached bit 0 of the register.
                res_d = res_q >> 1;
                res_d[WIDTH-1] = cell_diff;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_busy   = (state_q == ST_RUN);
    assign o_valid  = (state_q == ST_DONE);
    // After the last bit edge the borrow register holds the final borrow.
    assign o_diff   = res_q;
    assign o_borrow = br_q;

endmodule : serial_sub_ctrl
